// File: rtl/sort_scheduler_if.sv
// Valve-scheduling bus between the entry-sensor side (master) and sort_scheduler (slave).
// The flush signal exists only when SORT_FLUSH_EN is defined.
interface sort_scheduler_if #(
    parameter int DEPTH = 4
);
    // part_detect is a one-cycle push strobe with no back-pressure; part_ready is a one-cycle
    // issue strobe with no acknowledge, and the decision bits stay valid until the next issue.
    logic                     part_detect;
    logic                     valve1_req;
    logic                     valve2_req;
`ifdef SORT_FLUSH_EN
    logic                     flush;
`endif
    logic                     part_ready;
    logic                     valve1_decision;
    logic                     valve2_decision;
    logic [$clog2(DEPTH):0]   queue_count;
    logic                     busy;
    logic                     overflow;
    logic [1:0]               dbg_state;

`ifdef SORT_FLUSH_EN
    modport master (
        output part_detect, valve1_req, valve2_req, flush,
        input  part_ready, valve1_decision, valve2_decision, queue_count, busy, overflow,
               dbg_state
    );
    modport slave (
        input  part_detect, valve1_req, valve2_req, flush,
        output part_ready, valve1_decision, valve2_decision, queue_count, busy, overflow,
               dbg_state
    );
`else
    modport master (
        output part_detect, valve1_req, valve2_req,
        input  part_ready, valve1_decision, valve2_decision, queue_count, busy, overflow,
               dbg_state
    );
    modport slave (
        input  part_detect, valve1_req, valve2_req,
        output part_ready, valve1_decision, valve2_decision, queue_count, busy, overflow,
               dbg_state
    );
`endif
endinterface

// File: rtl/sort_scheduler.sv
// Timestamped valve-decision queue: issues each part's decision TRAVEL_CYCLES after detection,
// with at least HOLDOFF idle edges between issues. Define SORT_FLUSH_EN to add the flush input.
module sort_scheduler #(
    parameter int DEPTH         = 4,
    parameter int TRAVEL_CYCLES = 100000,
    parameter int HOLDOFF       = 1000,
    parameter int TW            = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_scheduler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;

    localparam logic [TW-1:0] LP_TRAVEL    = TW'(TRAVEL_CYCLES);
    localparam logic [CW-1:0] LP_FULL      = CW'(DEPTH);
    localparam logic [HW-1:0] LP_HOLD_LAST = HW'((HOLDOFF >= 2) ? (HOLDOFF - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_DUE = 2'd1,
        S_ISSUE    = 2'd2,
        S_HOLDOFF  = 2'd3
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_now;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [HW-1:0]   r_hold;
    logic            r_part_ready;
    logic            r_valve1;
    logic            r_valve2;
    logic            r_overflow;

    logic [TW-1:0]   r_stamp [DEPTH];
    logic [DEPTH-1:0] r_d1;
    logic [DEPTH-1:0] r_d2;

    logic            w_flush;
    logic            w_full;
    logic [TW-1:0]   w_age;
    logic            w_due;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_nonempty_next;
    logic            w_d1;
    logic            w_d2;

`ifdef SORT_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    // Modular age: correct across timestamp wrap as long as 2^TW exceeds the worst queue wait.
    assign w_full  = (r_count == LP_FULL);
    assign w_age   = r_now - r_stamp[r_rd_ptr];
    assign w_due   = (r_count != '0) && (w_age >= LP_TRAVEL);
    assign w_pop   = !w_flush && (r_state == S_WAIT_DUE) && w_due;
    assign w_push  = !w_flush && bus.part_detect && (!w_full || w_pop);
    assign w_drop  = !w_flush && bus.part_detect && w_full && !w_pop;
    assign w_nonempty_next = (r_count != '0) || w_push;

    // Valve 1 wins when both requests are raised.
    assign w_d1 = bus.valve1_req;
    assign w_d2 = bus.valve2_req & ~bus.valve1_req;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stamp[r_wr_ptr] <= r_now;
            r_d1[r_wr_ptr]    <= w_d1;
            r_d2[r_wr_ptr]    <= w_d2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_now        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hold       <= '0;
            r_part_ready <= 1'b0;
            r_valve1     <= 1'b0;
            r_valve2     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_now        <= r_now + TW'(1);
            r_part_ready <= 1'b0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_hold   <= '0;
                r_state  <= S_IDLE;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_push) begin
                            r_state <= S_WAIT_DUE;
                        end
                    end
                    S_WAIT_DUE: begin
                        if (w_pop) begin
                            r_state      <= S_ISSUE;
                            r_part_ready <= 1'b1;
                            r_valve1     <= r_d1[r_rd_ptr];
                            r_valve2     <= r_d2[r_rd_ptr];
                        end
                    end
                    S_ISSUE: begin
                        // The ISSUE cycle is the first of the HOLDOFF quiet edges.
                        r_hold <= '0;
                        if (HOLDOFF > 1) begin
                            r_state <= S_HOLDOFF;
                        end else begin
                            r_state <= w_nonempty_next ? S_WAIT_DUE : S_IDLE;
                        end
                    end
                    S_HOLDOFF: begin
                        if (r_hold == LP_HOLD_LAST) begin
                            r_state <= w_nonempty_next ? S_WAIT_DUE : S_IDLE;
                        end else begin
                            r_hold <= r_hold + HW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.part_ready      = r_part_ready;
    assign bus.valve1_decision = r_valve1;
    assign bus.valve2_decision = r_valve2;
    assign bus.queue_count     = r_count;
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.overflow        = r_overflow;
    assign bus.dbg_state       = r_state;

endmodule

// File: doc/sort_scheduler.md
Name: sort_scheduler

Overview:
Sequences the valve command stage of the sorting line. Each part seen at the entry sensor has its valve decision queued with a timestamp. When the part's conveyor travel time has elapsed, the block issues a one-cycle part_ready pulse together with the held valve1/valve2 decision bits. These outputs connect directly to the valve command block's part_ready/valve1_decision/valve2_decision inputs. A minimum hold-off between issues protects the shared air supply.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
TRAVEL_CYCLES, 100000, clock edges from sensor sample to issue (>=2)
HOLDOFF, 1000, minimum clock edges between successive part_ready pulses (>=1)
TW, 20, timestamp width; 2^TW must exceed TRAVEL_CYCLES + DEPTH*HOLDOFF

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
part_detect  in  1  one-cycle pulse from the entry sensor; samples valve1_req/valve2_req
valve1_req  in  1  decision: part goes to valve 1
valve2_req  in  1  decision: part goes to valve 2
part_ready  out  1  one-cycle issue pulse to the valve command stage
valve1_decision  out  1  registered decision, valid with part_ready, held until next issue
valve2_decision  out  1  registered decision, valid with part_ready, held until next issue
queue_count  out  $clog2(DEPTH)+1  entries pending
busy  out  1  high when state is not IDLE
overflow  out  1  sticky: a part_detect was dropped

Behaviour:
- Reset: asserting rst_n low clears all outputs to 0, empties the queue, zeroes the timestamp counter and puts the FSM in IDLE. Reset takes effect immediately, including mid-HOLDOFF or mid-ISSUE.
- Timestamp: free-running TW-bit counter `now`, incremented every cycle, wraps modulo 2^TW.
- Push: on part_detect, write {stamp=now, d1, d2} at the tail.
  - If valve1_req and valve2_req are both 1: d1=1, d2=0 (valve 1 has priority).
  - If neither is set, the entry is still queued (pass-through part) and issues with both decisions 0.
- Head due: (now - head.stamp) mod 2^TW >= TRAVEL_CYCLES. Only the head is checked; travel time is constant, so the queue stays in order.
- FSM:
  - IDLE: queue empty. On push -> WAIT_DUE.
  - WAIT_DUE: when the head is due -> ISSUE.
  - ISSUE (1 cycle): part_ready=1, decision outputs load the head bits, pop the head. Then -> HOLDOFF.
  - HOLDOFF: counts HOLDOFF cycles, then -> WAIT_DUE if the queue is non-empty, else IDLE.
- Latency: unblocked, part_ready is high exactly TRAVEL_CYCLES edges after the edge that sampled part_detect. A head that becomes due during HOLDOFF issues on the first WAIT_DUE cycle after HOLDOFF (late issue, no error).
- Push and pop in the same cycle: both take effect; queue_count is unchanged. A push into an empty queue becomes the head on the next cycle.
- Push while full with no pop that cycle: the part is dropped, overflow is set to 1, and overflow is cleared only by reset. Push while full with a pop that same cycle: accepted.
- queue_count changes the cycle after the push/pop edge. Read and write pointers wrap modulo DEPTH.
- part_detect held high for multiple cycles pushes once per cycle; upstream guarantees single-cycle pulses.

Optional Feature:
SORT_FLUSH_EN
- Defined: adds input port flush (1 bit). flush=1 empties the queue on the next edge, aborts HOLDOFF, and sends the FSM to IDLE. Decision outputs and overflow are unchanged. Flush has priority over a same-cycle push, which is dropped without setting overflow.
- Undefined: no flush port and no flush logic.

Test Plan:
Bench params: DEPTH=4, TRAVEL_CYCLES=50, HOLDOFF=10, TW=8.
- Single part: part_detect with valve1_req=1 at edge 0 -> part_ready=1 exactly at edge 50; valve1_decision=1, valve2_decision=0 held after; busy=0 after the 10-cycle holdoff.
- Back-to-back parts: detects at edges 0 (v2) and 3 (v1) -> issue at 50 (0,1); second issue at 61 (1,0), delayed by HOLDOFF; queue_count goes 1,2,1,0.
- Overflow: 5 detects on consecutive cycles -> queue_count=4, overflow=1, exactly 4 part_ready pulses spaced 11 cycles apart.
- Both requests set -> issues valve1_decision=1, valve2_decision=0; neither set -> pulse with both 0.
- Reset mid-operation: rst_n low at edge 55 during HOLDOFF with 2 entries queued -> all outputs 0 immediately; no further part_ready after release.
- Flush (SORT_FLUSH_EN defined): 3 entries queued, flush at edge 20 -> queue_count=0, busy=0, no part_ready through edge 200.
